uart_tx_buffered: RTL
=====================

// Module: uart_tx_buffered
// PURPOSE
//  8N1 UART transmitter, LSB first; counterpart of the core UART receiver on the same line rate.
//  Accepts bytes from the core (e.g. MMIO/out instruction) via valid/ready, serialises them on txd.
//  Optional TX FIFO decouples core stalls from line rate; back-to-back frames with no idle gap.
// PARAMETERS
//  CLK_PER_HALF_BIT  434  clocks per half bit; bit period = 2*CLK_PER_HALF_BIT clocks
//  FIFO_DEPTH_LOG2   4    log2 of TX FIFO entries (used only with UART_TX_FIFO_EN)
// PORTS
//  clk        in   1  clock
//  rstn       in   1  reset, synchronous, active-low
//  wr_data    in   8  byte to send
//  wr_valid   in   1  wr_data valid; byte accepted on cycle with wr_valid & wr_ready
//  wr_ready   out  1  block can accept a byte this cycle
//  txd        out  1  serial line, idle high, registered
//  busy       out  1  frame in progress or bytes pending
//  tx_done    out  1  1-cycle pulse at end of each stop bit
// BEHAVIOUR
//  Reset: txd=1, wr_ready=1, busy=0, tx_done=0, state=IDLE, counter=0, FIFO empty.
//  Baud counter: width $clog2(2*CLK_PER_HALF_BIT); counts 0..2*CLK_PER_HALF_BIT-1; tick at
//   terminal count, wraps to 0; held at 0 in IDLE; cleared on frame start.
//  FSM: IDLE -> START -> DATA (bit_idx 0..7) -> STOP -> IDLE or START.
//   IDLE: if byte available, load shift reg, txd<=0 next edge, go START.
//   START/DATA/STOP each last exactly one bit period (tick ends state).
//   DATA: txd=shift[0], shift right on tick; after bit_idx 7 tick -> STOP (txd=1).
//   STOP tick: pulse tx_done; if byte available load it, go START directly (txd<=0 same edge,
//    zero idle clocks between frames); else IDLE.
//  Frame = 10 bit periods = 20*CLK_PER_HALF_BIT clocks from txd fall to end of stop bit.
//  Accept-to-txd-fall latency from IDLE: 1 clock (no FIFO), 2 clocks (FIFO: push then pop).
//  busy = (state!=IDLE) | byte pending; drops the cycle after final tx_done.
//  Reset mid-frame: txd=1 next edge, frame aborted, FIFO/holding reg flushed, no tx_done.
//  wr_valid with wr_ready=0: ignored, data must be held by source (no loss, no overwrite).
// CONFIGURATION
//  UART_TX_FIFO_EN defined: FIFO of 2**FIFO_DEPTH_LOG2 bytes in front of shift reg;
//   wr_ready = !full (registered count, push when full refused even if pop same cycle);
//   push and pop same cycle when non-empty/non-full both occur, count unchanged.
//   Total capacity = FIFO depth + 1 (shift reg).
//  UART_TX_FIFO_EN undefined: single holding register; wr_ready = !hold_valid;
//   holding reg freed when loaded into shift reg, so one byte can queue behind active frame.
// STRUCTURE
//  uart_pkg: tx state enum (IDLE/START/DATA/STOP), DATA_BITS=8, frame bit constants.
//  Sub-module uart_tx_fifo (sync FIFO: push/pop/full/empty/count, synchronous rstn),
//   instantiated only under UART_TX_FIFO_EN; top holds FSM, baud counter, shift reg.
// TESTING (CLK_PER_HALF_BIT=4 -> 8 clk/bit, 80 clk/frame)
//  Send 0x55 from idle -> txd 0,1,0,1,0,1,0,1,0,1 each held 8 clk; tx_done once at clk 80.
//  Loopback to core UART receiver, send 0xA3, 0x00, 0xFF -> rdata matches each, ferr=0.
//  Push 3 bytes back-to-back -> txd low again on clock after stop bit ends; 240 clk total, busy
//   high throughout, low 1 clk after third tx_done.
//  FIFO_EN, depth 16: hold wr_valid for 20 bytes -> 17 accepted immediately, wr_ready low,
//   resumes one byte per frame; all 20 bytes received in order.
//  No FIFO: push during frame -> accepted once; second push stalls until next frame start.
//  Assert rstn=0 at clk 30 of a frame -> txd=1 next edge, busy=0, no tx_done, receiver idle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered 8N1 UART transmitter: FSM state encoding and frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte write channel into the UART transmitter: valid/ready handshake with 8-bit payload.
interface uart_tx_buffered_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO sitting in front of the transmitter shift register.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Full is taken from the registered count, so a push into a full FIFO is refused even if a pop happens the same cycle.
    assign full     = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter, LSB first, frames sent back to back with no idle gap.
// Define UART_TX_FIFO_EN to place a 2**FIFO_DEPTH_LOG2 byte FIFO in front of the shift register.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int FIFO_DEPTH_LOG2  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    uart_tx_buffered_if.slave    wr,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int CW       = $clog2(BIT_CLKS);
    localparam int IW       = $clog2(DATA_BITS);

    tx_state_t            state;
    tx_state_t            state_next;
    logic [CW-1:0]        cnt;
    logic                 tick;
    logic                 load;
    logic                 avail;
    logic                 pending;
    logic [DATA_BITS-1:0] load_data;
    logic [DATA_BITS-1:0] shift;
    logic [IW-1:0]        bit_idx;

`ifdef UART_TX_FIFO_EN
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;

    uart_tx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (wr.wr_valid),
        .push_data (wr.wr_data),
        .pop       (load),
        .pop_data  (load_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign wr.wr_ready = !fifo_full;
    assign avail       = !fifo_empty;
    assign pending     = (fifo_count != '0);
`else
    logic                 hold_valid;
    logic [DATA_BITS-1:0] hold_data;

    // An idle transmitter takes the incoming byte straight into the shift register; only a byte
    // arriving while a frame is running is parked in the holding register.
    assign wr.wr_ready = !hold_valid;
    assign avail       = hold_valid || wr.wr_valid;
    assign load_data   = hold_valid ? hold_data : wr.wr_data;
    assign pending     = hold_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_valid <= 1'b0;
        end else if (hold_valid) begin
            if (load) begin
                hold_valid <= 1'b0;
            end
        end else if (wr.wr_valid && !load) begin
            hold_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr.wr_valid && !hold_valid) begin
            hold_data <= wr.wr_data;
        end
    end
`endif

    assign tick = (cnt == CW'(BIT_CLKS - 1));
    assign busy = (state != IDLE) || pending;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A stop-bit tick with another byte ready goes straight to START so frames abut.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        tx_done    = 1'b0;
        case (state)
            IDLE: begin
                if (avail) begin
                    load       = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick && (bit_idx == IW'(DATA_BITS - 1))) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    tx_done = 1'b1;
                    if (avail) begin
                        load       = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load || (state == IDLE) || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // txd is driven one bit ahead from the shift register so the line changes on the tick edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            txd     <= STOP_BIT;
            shift   <= '0;
            bit_idx <= '0;
        end else if (load) begin
            shift   <= load_data;
            txd     <= START_BIT;
            bit_idx <= '0;
        end else if (tick) begin
            case (state)
                START: txd <= shift[0];
                DATA: begin
                    if (bit_idx == IW'(DATA_BITS - 1)) begin
                        txd <= STOP_BIT;
                    end else begin
                        txd     <= shift[1];
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP:    txd <= STOP_BIT;
                default: txd <= STOP_BIT;
            endcase
        end
    end

endmodule
